multiphase_clk_gen: RTL



---
 rtl/clk_phase_pkg.sv | 45 ++++
 rtl/clk_phase_prescaler.sv | 50 +++++
 rtl/multiphase_clk_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/clk_phase_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_phase_pkg
// Purpose  : Shared types and helpers for the multiphase clock generator:
//            FSM state encoding, Johnson-counter step function and the
//            phase-count legality check used at elaboration time.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clk_phase_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } phase_state_e;

   // Widest Johnson register the step helper can handle (NUM_PHASES/2).
   localparam int MAX_L = 32;

   // One Johnson step on the low 'len' bits: shift left, feed back the
   // inverted MSB. Bits at or above 'len' are returned as zero.
   function automatic logic [MAX_L-1:0] johnson_next(input logic [MAX_L-1:0] j,
                                                     input int len);
      logic [MAX_L-1:0] nxt;
      logic             msb;
      nxt = '0;
      msb = 1'b0;
      for (int i = 0; i < MAX_L; i++) begin
         if (i == len - 1) msb = j[i];
      end
      for (int i = 0; i < MAX_L; i++) begin
         if (i == 0)        nxt[i] = ~msb;
         else if (i < len)  nxt[i] = j[i-1];
      end
      return nxt;
   endfunction

   // Even phase count, at least four, and within the helper's reach.
   function automatic bit num_phases_ok(input int n);
      return (n >= 4) && ((n % 2) == 0) && ((n / 2) <= MAX_L);
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_phase_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : clk_phase_prescaler
// Purpose  : Programmable tick prescaler. Counts 0..div_act and emits a
//            one-cycle tick when the count reaches div_act. The active
//            divider is only replaced on 'reload', which the parent asserts
//            when the count is being cleared, so cnt never exceeds div_act.
// Ports    : clk, rst_n        - clock, async active-low reset
//            run              - count enable; counter held at 0 when low
//            reload           - capture div_val into the active divider
//            div_val[DIV_W]   - requested divider value
//            tick             - combinational step strobe
// Revision : 1.0 - initial release
// ============================================================================
module clk_phase_prescaler #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             reload,
   input  logic [DIV_W-1:0] div_val,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_act_q, div_act_d;

   assign tick = run && (cnt_q == div_act_q);

   always_comb begin
      cnt_d     = cnt_q;
      div_act_d = div_act_q;
      if (!run || tick) cnt_d = '0;
      else              cnt_d = cnt_q + DIV_W'(1);
      if (reload)       div_act_d = div_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         div_act_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         div_act_q <= div_act_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/multiphase_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : multiphase_clk_gen
// Purpose  : N-phase 50%-duty clock generator built from a Johnson counter
//            of length NUM_PHASES/2 and its inversions, stepped by a
//            programmable prescaler. Run/stop control always stops on the
//            all-zero boundary so outputs never emit runt pulses.
// Ports    : clk, rst_n              - clock, async active-low reset
//            en                      - run request (level)
//            div_val[DIV_W]          - step every div_val+1 cycles
//            phase_sel[SEL_W]        - phase routed to clk_sel (IDLE-sampled)
//            phase_out[NUM_PHASES]   - phase k lags phase 0 by k steps
//            clk_sel                 - registered copy of selected phase
//            running                 - high in RUN and STOPPING
//            period_start            - pulse as phase_out[0] rises
// Revision : 1.0 - initial release
// ============================================================================
module multiphase_clk_gen
   import clk_phase_pkg::*;
#(
   parameter  int NUM_PHASES = 4,
   parameter  int DIV_W      = 4,
   localparam int SEL_W      = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DIV_W-1:0]      div_val,
   input  logic [SEL_W-1:0]      phase_sel,
   output logic [NUM_PHASES-1:0] phase_out,
   output logic                  clk_sel,
   output logic                  running,
   output logic                  period_start
);

   localparam int L = NUM_PHASES / 2;

   generate
      if (!num_phases_ok(NUM_PHASES)) begin : g_bad_num_phases
         $error("multiphase_clk_gen: NUM_PHASES must be even and >= 4");
      end
      if (DIV_W < 1) begin : g_bad_div_w
         $error("multiphase_clk_gen: DIV_W must be >= 1");
      end
   endgenerate

   phase_state_e     state_q, state_d;
   logic [L-1:0]     j_q, j_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             clk_sel_q, clk_sel_d;
   logic             running_q, running_d;
   logic             period_start_q, period_start_d;

   logic             tick;
   logic             reload;
   logic             wrap;
   logic [MAX_L-1:0] j_ext;
   logic [MAX_L-1:0] j_next_full;
   logic [L-1:0]     j_step;
   logic             unused_j_hi;

   clk_phase_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state_q != ST_IDLE),
      .reload  (reload),
      .div_val (div_val),
      .tick    (tick)
   );

   // Outputs are flop bits or their inverters only, so every phase is
   // glitch-free and they all share one clock-to-out path.
   generate
      for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
         if (k < L) begin : g_direct
            assign phase_out[k] = j_q[k];
         end else begin : g_inverted
            assign phase_out[k] = ~j_q[k-L];
         end
      end
   endgenerate

   always_comb begin
      j_ext          = '0;
      j_ext[L-1:0]   = j_q;
      j_next_full    = johnson_next(j_ext, L);
      j_step         = j_next_full[L-1:0];
      unused_j_hi    = |j_next_full;

      // A tick that returns the counter to zero closes a full period.
      wrap           = tick && (j_step == '0);

      state_d        = state_q;
      j_d            = j_q;
      sel_d          = sel_q;
      if (tick) j_d  = j_step;

      unique case (state_q)
         ST_IDLE: begin
            sel_d = phase_sel;
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en) state_d = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (en)        state_d = ST_RUN;
            else if (wrap) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // New divider only at a period boundary, so periods never mix values.
      reload         = ((state_q == ST_IDLE) && en) || wrap;

      running_d      = (state_d != ST_IDLE);
      period_start_d = tick && (j_q == '0);

      // Out-of-range selects (non power-of-two phase counts) read as 0.
      if ({1'b0, sel_q} < (SEL_W+1)'(NUM_PHASES)) clk_sel_d = phase_out[sel_q];
      else                                        clk_sel_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         j_q            <= '0;
         sel_q          <= '0;
         clk_sel_q      <= 1'b0;
         running_q      <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         j_q            <= j_d;
         sel_q          <= sel_d;
         clk_sel_q      <= clk_sel_d;
         running_q      <= running_d;
         period_start_q <= period_start_d;
      end
   end

   assign clk_sel      = clk_sel_q;
   assign running      = running_q;
   assign period_start = period_start_q;

endmodule
`default_nettype wire
